aes_enc_multi: RTL and testbench

AES_ENC_MULTI -- requirements
Module: aes_enc_multi

---
 rtl/aes_enc_multi.sv | 234 +++++++++++++++++++++++
 tb/tb_aes_enc_multi.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/aes_enc_multi.sv
// aes_enc_multi: iterative AES encryptor for 128/192/256-bit keys.
// One schedule word is produced per cycle in KEXP. One round is executed per
// cycle in ROUND. The last expanded schedule is kept, so a request that repeats
// the same mode and key skips KEXP.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready, mode, in, key   request handshake and operands
//   out_valid/out_ready, out, err      result handshake; err marks an illegal mode
//   busy           state is not IDLE
//
// state | meaning
// IDLE  | waiting for a request
// KEXP  | expanding the key schedule, one word per cycle
// ROUND | round 0 (AddRoundKey), then rounds 1..Nr, one per cycle
// DONE  | result held until out_ready
module aes_enc_multi #(
    parameter int MAX_KEY_LEN = 256,
    parameter int CACHE_EN    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             mode,
    input  logic [127:0]           in,
    input  logic [MAX_KEY_LEN-1:0] key,
    output logic [127:0]           out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   err,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254, zero maps to zero) then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq, inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[8*k +: 8] = sbox(s[8*k +: 8]);
        return o;
    endfunction

    // Byte k of the block sits at bits [127-8k -: 8]; byte (row r, col c) is k = 4c + r.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    state_t                 state, state_d;
    logic [5:0]             cnt;          // schedule word index in KEXP, round in ROUND
    logic [2:0]             kidx;         // schedule word index mod Nk
    logic [7:0]             rc;           // current Rcon byte
    logic [1:0]             mode_q;
    logic [127:0]           st;
    logic                   err_q;
    logic                   sched_valid;
    logic [1:0]             cache_mode;
    logic [MAX_KEY_LEN-1:0] cache_key;
    logic [31:0]            w [0:59];

    logic                   accept, illegal_in, hit;
    logic [5:0]             nk_in, w_last;
    logic [3:0]             nk, nr;
    logic [31:0]            w_prev, w_far, ks_temp, w_new;
    logic [5:0]             rk_base;
    logic [127:0]           rk, sb_sr, rnd;

    assign illegal_in = (mode == 2'd3) || (mode == 2'd1 && MAX_KEY_LEN < 192) ||
                        (mode == 2'd2 && MAX_KEY_LEN < 256);
    assign hit   = (CACHE_EN != 0) && sched_valid && cache_mode == mode && cache_key == key;
    assign nk_in = (mode == 2'd2) ? 6'd8 : (mode == 2'd1) ? 6'd6 : 6'd4;

    always_comb begin
        case (mode_q)
            2'd1:    begin nk = 4'd6; nr = 4'd12; w_last = 6'd51; end
            2'd2:    begin nk = 4'd8; nr = 4'd14; w_last = 6'd59; end
            default: begin nk = 4'd4; nr = 4'd10; w_last = 6'd43; end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_d;
    end

    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                busy     = 1'b0;
                in_ready = rst;
                accept   = in_valid && rst;
                if (accept) state_d = illegal_in ? DONE : (hit ? ROUND : KEXP);
            end
            KEXP:  if (cnt == w_last) state_d = ROUND;
            ROUND: if (cnt[3:0] == nr) state_d = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign out = out_valid ? st : 128'h0;
    assign err = out_valid & err_q;

    // FIPS-197 KeyExpansion step for word cnt.
    always_comb begin
        w_prev  = w[cnt - 6'd1];
        w_far   = w[cnt - {2'b00, nk}];
        ks_temp = w_prev;
        if (kidx == 3'd0)
            ks_temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rc, 24'h0};
        else if (nk == 4'd8 && kidx == 3'd4)
            ks_temp = sub_word(w_prev);
        w_new = w_far ^ ks_temp;
    end

    always_comb begin
        rk_base = {cnt[3:0], 2'b00};
        rk      = {w[rk_base], w[rk_base + 6'd1], w[rk_base + 6'd2], w[rk_base + 6'd3]};
        sb_sr   = shift_rows(sub_bytes(st));
        if (cnt == 6'd0)          rnd = st ^ rk;
        else if (cnt[3:0] == nr)  rnd = sb_sr ^ rk;
        else                      rnd = mix_columns(sb_sr) ^ rk;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= 6'd0;
            kidx        <= 3'd0;
            rc          <= 8'h01;
            mode_q      <= 2'd0;
            st          <= 128'h0;
            err_q       <= 1'b0;
            sched_valid <= 1'b0;
            cache_mode  <= 2'd0;
            cache_key   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    mode_q <= mode;
                    err_q  <= illegal_in;
                    kidx   <= 3'd0;
                    rc     <= 8'h01;
                    cnt    <= 6'd0;
                    st     <= illegal_in ? 128'h0 : in;
                    if (!illegal_in && !hit) begin
                        cnt         <= nk_in;
                        sched_valid <= 1'b0;
                        cache_mode  <= mode;
                        cache_key   <= key;
                    end
                end
                KEXP: begin
                    cnt  <= (cnt == w_last) ? 6'd0 : cnt + 6'd1;
                    kidx <= ({1'b0, kidx} == nk - 4'd1) ? 3'd0 : kidx + 3'd1;
                    if (kidx == 3'd0) rc <= xtime(rc);
                    if (cnt == w_last) sched_valid <= 1'b1;
                end
                ROUND: begin
                    st  <= rnd;
                    cnt <= cnt + 6'd1;
                end
                default: ;
            endcase
        end
    end

    // Schedule store has no reset; sched_valid alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (state == IDLE && accept && !illegal_in && !hit) begin
            for (int j = 0; j < MAX_KEY_LEN / 32; j++)
                w[j] <= key[MAX_KEY_LEN-1-32*j -: 32];
        end else if (state == KEXP) begin
            w[cnt] <= w_new;
        end
    end
endmodule

// File: tb/tb_aes_enc_multi.sv
module tb_aes_enc_multi;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0, out_ready = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic [127:0] din = 128'h0;
    logic [255:0] key = 256'h0;
    logic         in_ready, out_valid, err, busy;
    logic [127:0] dout;

    logic         s_in_valid = 1'b0, s_out_ready = 1'b0;
    logic         s_in_ready, s_out_valid, s_err, s_busy;
    logic [127:0] s_dout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    aes_enc_multi #(.MAX_KEY_LEN(256), .CACHE_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .in(din), .key(key), .out(dout), .out_valid(out_valid), .out_ready(out_ready),
        .err(err), .busy(busy));

    aes_enc_multi #(.MAX_KEY_LEN(128), .CACHE_EN(1)) dut128 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .mode(mode),
        .in(din), .key(key[255:128]), .out(s_dout), .out_valid(s_out_valid),
        .out_ready(s_out_ready), .err(s_err), .busy(s_busy));

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request on the selected DUT; return cycles until out_valid is seen.
    task automatic send(input bit sel, input logic [1:0] m, input logic [255:0] k,
                        input logic [127:0] p, output int lat,
                        output logic [127:0] o, output logic e);
        @(negedge clk);
        mode = m; key = k; din = p;
        if (sel) s_in_valid = 1'b1; else in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; s_in_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!(sel ? s_out_valid : out_valid) && lat < 300);
        o = sel ? s_dout : dout;
        e = sel ? s_err : err;
    endtask

    task automatic drain(input bit sel, input string tag);
        @(negedge clk);
        if (sel) s_out_ready = 1'b1; else out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; s_out_ready = 1'b0;
        chk({tag, " idle"}, {126'h0, sel ? s_busy : busy, sel ? s_in_ready : in_ready}, 128'h1);
    endtask

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    initial begin
        logic [255:0] k128, k192, k256, k256x;
        logic [127:0] o, held;
        logic         e;
        int           lat;
        k128  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        k192  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        k256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        k256x = k256 ^ (256'h1 << 100);

        #12;
        chk("rst held in_ready", {127'h0, in_ready}, 128'h0);
        chk("rst held outputs", {dout ^ 128'h0, out_valid, err, busy}, {128'h0, 3'b000});
        @(negedge clk); rst = 1'b1;
        #1;
        chk("rst released in_ready", {127'h0, in_ready}, 128'h1);

        send(0, 2'd0, k128, PT, lat, o, e);
        chk("aes128 out", o, CT128); chk("aes128 err", {127'h0, e}, 128'h0);
        chk("aes128 lat", lat, 51); drain(0, "aes128");

        send(0, 2'd1, k192, PT, lat, o, e);
        chk("aes192 out", o, CT192); chk("aes192 lat", lat, 59); drain(0, "aes192");

        send(0, 2'd2, k256, PT, lat, o, e);
        chk("aes256 out", o, CT256); chk("aes256 lat", lat, 67); drain(0, "aes256");

        send(0, 2'd2, k256, PT, lat, o, e);
        chk("hit out", o, CT256); chk("hit lat", lat, 15); drain(0, "hit");

        send(0, 2'd3, k256, PT, lat, o, e);
        chk("mode3 out", o, 128'h0); chk("mode3 err", {127'h0, e}, 128'h1);
        chk("mode3 lat", lat, 1); drain(0, "mode3");

        send(0, 2'd2, k256, PT, lat, o, e);
        chk("hit after illegal out", o, CT256); chk("hit after illegal lat", lat, 15);
        drain(0, "hit2");

        send(0, 2'd2, k256x, PT, lat, o, e);
        chk("keybit miss lat", lat, 67); chk("keybit miss err", {127'h0, e}, 128'h0);
        chk("keybit out differs", {127'h0, o != CT256}, 128'h1);
        drain(0, "keybit");

        // Backpressure: result must stay put and new requests must be ignored.
        send(0, 2'd0, k128, PT, lat, o, e);
        chk("bp lat", lat, 51);
        held = dout;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1; din = ~PT; mode = 2'd0;
            @(posedge clk); #1;
            chk("bp out stable", dout, CT128);
            chk("bp flags", {125'h0, out_valid, in_ready, err}, {125'h0, 3'b100});
        end
        chk("bp held", held, CT128);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp release", {126'h0, busy, out_valid}, 128'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp no stray request", {126'h0, busy, out_valid}, 128'h0);

        send(1, 2'd1, k192, PT, lat, o, e);
        chk("max128 mode1 out", o, 128'h0); chk("max128 mode1 err", {127'h0, e}, 128'h1);
        chk("max128 mode1 lat", lat, 1); drain(1, "max128 mode1");
        send(1, 2'd0, k128, PT, lat, o, e);
        chk("max128 aes128 out", o, CT128); chk("max128 aes128 lat", lat, 51);
        drain(1, "max128 aes128");

        // Reset 20 cycles into key expansion.
        @(negedge clk);
        mode = 2'd0; key = k128; din = PT; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("mid kexp busy", {127'h0, busy}, 128'h1);
        rst = 1'b0;
        #1;
        chk("abort outputs", {dout, out_valid, err, busy, in_ready}, {128'h0, 4'b0000});
        @(negedge clk); rst = 1'b1;
        #1;
        chk("abort in_ready", {127'h0, in_ready}, 128'h1);
        send(0, 2'd0, k128, PT, lat, o, e);
        chk("post-reset out", o, CT128); chk("post-reset lat", lat, 51);
        drain(0, "post-reset");
        send(0, 2'd0, k128, PT, lat, o, e);
        chk("post-reset hit out", o, CT128); chk("post-reset hit lat", lat, 11);
        drain(0, "post-reset hit");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
